// File: rtl/cpu_state_dumper.sv
// Streams the register file and then a data-memory window as 32-bit words.
// Register words go out back-to-back; each memory word is gathered big-endian.
module cpu_state_dumper #(
    parameter int NUM_REGS      = 32,
    parameter int NUM_MEM_BYTES = 32,
    parameter int MEM_BASE      = 0,
    parameter int DM_ADDR_W     = 7
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    output logic [4:0]           rf_addr_o,
    input  logic [31:0]          rf_data_i,
    output logic [DM_ADDR_W-1:0] dm_addr_o,
    input  logic [7:0]           dm_data_i,
    output logic [31:0]          dump_data_o,
    output logic                 dump_valid_o,
    input  logic                 dump_ready_i,
    output logic                 dump_last_o,
    output logic                 busy_o,
    output logic                 done_o
);

    // One spare bit so the pointer can sit at the end of a window reaching 2**DM_ADDR_W.
    localparam int PW = DM_ADDR_W + 1;
    localparam logic [PW-1:0] BASE  = PW'(MEM_BASE);
    localparam logic [PW-1:0] LIMIT = PW'(MEM_BASE + NUM_MEM_BYTES);
    localparam logic [5:0]    NREGS = 6'(NUM_REGS);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] REG    = 2'd1;
    localparam logic [1:0] GATHER = 2'd2;
    localparam logic [1:0] SEND   = 2'd3;

    logic [1:0]    state;
    logic [5:0]    reg_idx;
    logic [PW-1:0] byte_ptr;
    logic [1:0]    byte_cnt;
    logic [23:0]   shift;
    logic          xfer;

    assign xfer      = dump_valid_o & dump_ready_i;
    assign rf_addr_o = reg_idx[4:0];
    assign dm_addr_o = byte_ptr[DM_ADDR_W-1:0];
    assign busy_o    = (state != IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            reg_idx      <= '0;
            byte_ptr     <= BASE;
            byte_cnt     <= '0;
            shift        <= '0;
            dump_data_o  <= '0;
            dump_valid_o <= 1'b0;
            dump_last_o  <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            done_o <= 1'b0;
            unique case (1'b1)
                (state == IDLE): begin
                    if (start_i) begin
                        dump_data_o  <= rf_data_i;
                        dump_valid_o <= 1'b1;
                        dump_last_o  <= 1'b0;
                        reg_idx      <= 6'd1;
                        state        <= REG;
                    end
                end
                (state == REG): begin
                    if (xfer) begin
                        if (reg_idx < NREGS) begin
                            dump_data_o <= rf_data_i;
                            reg_idx     <= reg_idx + 6'd1;
                        end else begin
                            dump_valid_o <= 1'b0;
                            byte_cnt     <= '0;
                            state        <= GATHER;
                        end
                    end
                end
                (state == GATHER): begin
                    shift    <= {shift[15:0], dm_data_i};
                    byte_ptr <= byte_ptr + PW'(1);
                    byte_cnt <= byte_cnt + 2'd1;
                    if (byte_cnt == 2'd3) begin
                        dump_data_o  <= {shift, dm_data_i};
                        dump_valid_o <= 1'b1;
                        dump_last_o  <= (byte_ptr + PW'(1) == LIMIT);
                        state        <= SEND;
                    end
                end
                (state == SEND): begin
                    if (xfer) begin
                        dump_valid_o <= 1'b0;
                        byte_cnt     <= '0;
                        if (dump_last_o) begin
                            dump_last_o <= 1'b0;
                            done_o      <= 1'b1;
                            reg_idx     <= '0;
                            byte_ptr    <= BASE;
                            state       <= IDLE;
                        end else begin
                            state <= GATHER;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_state_dumper.sv
// Directed bench for cpu_state_dumper: default window plus a small offset window.
// Expected words are queued at start and consumed by per-DUT stream monitors.
module tb_cpu_state_dumper;

    typedef struct {
        logic [31:0] d;
        logic        l;
        int          g;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // DUT 1: default parameters
    logic        rst, start, rdy;
    logic [4:0]  rf_a1;
    logic [31:0] rf_d1;
    logic [6:0]  dm_a1;
    logic [7:0]  dm_d1;
    logic [31:0] data1;
    logic        valid1, last1, busy1, done1;
    logic [7:0]  mem1 [0:127];

    assign rf_d1 = 32'(rf_a1) * 32'd3;
    assign dm_d1 = mem1[dm_a1];

    cpu_state_dumper dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .rf_addr_o(rf_a1), .rf_data_i(rf_d1),
        .dm_addr_o(dm_a1), .dm_data_i(dm_d1),
        .dump_data_o(data1), .dump_valid_o(valid1),
        .dump_ready_i(rdy), .dump_last_o(last1),
        .busy_o(busy1), .done_o(done1)
    );

    // DUT 2: small offset window
    logic        start2, rdy2;
    logic [4:0]  rf_a2;
    logic [31:0] rf_d2;
    logic [6:0]  dm_a2;
    logic [7:0]  dm_d2;
    logic [31:0] data2;
    logic        valid2, last2, busy2, done2;
    logic [7:0]  mem2 [0:127];

    assign rf_d2 = 32'(rf_a2) * 32'd3;
    assign dm_d2 = mem2[dm_a2];

    cpu_state_dumper #(
        .NUM_REGS(2), .NUM_MEM_BYTES(4), .MEM_BASE(8), .DM_ADDR_W(7)
    ) dut2 (
        .clk_i(clk), .rst_i(rst), .start_i(start2),
        .rf_addr_o(rf_a2), .rf_data_i(rf_d2),
        .dm_addr_o(dm_a2), .dm_data_i(dm_d2),
        .dump_data_o(data2), .dump_valid_o(valid2),
        .dump_ready_i(rdy2), .dump_last_o(last2),
        .busy_o(busy2), .done_o(done2)
    );

    exp_t q1[$];
    exp_t q2[$];
    int   cyc = 0;
    int   lastc1 = 0;
    logic pv1 = 0, pr1 = 0, pl1 = 0;
    logic [31:0] pd1 = 0;
    logic ed1 = 0, ed2 = 0;
    int   nx1 = 0;

    always @(posedge clk) cyc++;

    // Stream monitor for DUT 1: hold, order, spacing, last and done
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            pv1 = 0; ed1 = 0;
        end else begin
            if (pv1 && !pr1) begin
                chk("hold_valid", 32'(valid1), 32'd1);
                chk("hold_data", data1, pd1);
                chk("hold_last", 32'(last1), 32'(pl1));
            end
            chk("done1", 32'(done1), 32'(ed1));
            ed1 = 0;
            if (valid1 && rdy) begin
                nx1++;
                chk("q1_has_word", 32'(q1.size() != 0), 32'd1);
                if (q1.size() != 0) begin
                    e = q1.pop_front();
                    chk("word1", data1, e.d);
                    chk("last1", 32'(last1), 32'(e.l));
                    if (e.g != 0) chk("gap1", 32'(cyc - lastc1), 32'(e.g));
                    if (e.l) ed1 = 1;
                end
                lastc1 = cyc;
            end
            pv1 = valid1; pr1 = rdy; pd1 = data1; pl1 = last1;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            ed2 = 0;
        end else begin
            chk("done2", 32'(done2), 32'(ed2));
            ed2 = 0;
            if (valid2 && rdy2) begin
                chk("q2_has_word", 32'(q2.size() != 0), 32'd1);
                if (q2.size() != 0) begin
                    e = q2.pop_front();
                    chk("word2", data2, e.d);
                    chk("last2", 32'(last2), 32'(e.l));
                    if (e.l) ed2 = 1;
                end
            end
        end
    end

    task automatic push_dump(input bit gaps);
        exp_t e;
        for (int k = 0; k < 32; k++) begin
            e.d = 32'(3 * k);
            e.l = 1'b0;
            e.g = (gaps && k > 0) ? 1 : 0;
            q1.push_back(e);
        end
        for (int w = 0; w < 8; w++) begin
            e.d = {8'(4*w), 8'(4*w+1), 8'(4*w+2), 8'(4*w+3)};
            e.l = (w == 7);
            e.g = gaps ? 5 : 0;
            q1.push_back(e);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (done1) break;
        end
        chk("done_seen", 32'(done1), 32'd1);
        chk("busy_at_done", 32'(busy1), 32'd0);
    endtask

    task automatic wait_valid_data(input logic [31:0] v, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (valid1 && data1 == v) break;
        end
        chk("found_word", data1, v);
    endtask

    initial begin
        exp_t e;
        for (int i = 0; i < 128; i++) begin
            mem1[i] = 8'(i);
            mem2[i] = 8'hEE;
        end
        mem2[8] = 8'hAA; mem2[9] = 8'hBB;
        mem2[10] = 8'hCC; mem2[11] = 8'hDD;
        rst = 1; start = 0; rdy = 1; start2 = 0; rdy2 = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;

        chk("rst_valid", 32'(valid1), 32'd0);
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_data", data1, 32'd0);
        chk("rst_rfaddr", 32'(rf_a1), 32'd0);
        chk("rst_dmaddr2", 32'(dm_a2), 32'd8);

        // Plain dump with ready held high
        push_dump(1);
        pulse_start();
        wait_done(300);
        repeat (5) @(posedge clk);
        #1 chk("q1_empty_a", 32'(q1.size()), 32'd0);
        chk("count_a", 32'(nx1), 32'd40);

        // Backpressure on a register word and on a memory word
        nx1 = 0;
        push_dump(0);
        pulse_start();
        wait_valid_data(32'd15, 50);
        rdy = 0;
        repeat (3) @(posedge clk);
        #1 chk("bp_reg_hold", data1, 32'd15);
        rdy = 1;
        wait_valid_data(32'h08090A0B, 100);
        rdy = 0;
        repeat (3) @(posedge clk);
        #1 chk("bp_mem_hold", data1, 32'h08090A0B);
        rdy = 1;
        wait_done(300);
        #1 chk("q1_empty_b", 32'(q1.size()), 32'd0);
        chk("count_b", 32'(nx1), 32'd40);

        // Start pulses while busy are ignored
        nx1 = 0;
        push_dump(1);
        pulse_start();
        repeat (5) @(posedge clk);
        #1 pulse_start();
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (!valid1) break;
        end
        chk("in_gather", 32'(busy1 && !valid1), 32'd1);
        pulse_start();
        wait_done(300);
        repeat (10) @(posedge clk);
        #1 chk("q1_empty_c", 32'(q1.size()), 32'd0);
        chk("count_c", 32'(nx1), 32'd40);
        chk("idle_c", 32'(busy1), 32'd0);

        // Reset in the second gather cycle of 0x04050607
        push_dump(1);
        pulse_start();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (valid1 && rdy && data1 == 32'h00010203) break;
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        chk("mid_rst_valid", 32'(valid1), 32'd0);
        chk("mid_rst_busy", 32'(busy1), 32'd0);
        chk("mid_rst_rfaddr", 32'(rf_a1), 32'd0);
        chk("mid_rst_dmaddr", 32'(dm_a1), 32'd0);
        chk("mid_rst_left", 32'(q1.size()), 32'd7);
        q1.delete();

        // Fresh dump, then restart in its done cycle
        push_dump(1);
        pulse_start();
        push_dump(1);
        wait_done(300);
        start = 1;
        @(posedge clk); #1;
        start = 0;
        chk("restart_valid", 32'(valid1), 32'd1);
        chk("restart_data", data1, 32'd0);
        wait_done(300);
        repeat (3) @(posedge clk);
        #1 chk("q1_empty_d", 32'(q1.size()), 32'd0);

        // Offset window instance
        e.g = 0;
        e.d = 32'd0;        e.l = 0; q2.push_back(e);
        e.d = 32'd3;        e.l = 0; q2.push_back(e);
        e.d = 32'hAABBCCDD; e.l = 1; q2.push_back(e);
        start2 = 1;
        @(posedge clk); #1;
        start2 = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (done2) break;
        end
        chk("done2_seen", 32'(done2), 32'd1);
        @(posedge clk); #1;
        chk("done2_pulse", 32'(done2), 32'd0);
        chk("q2_empty", 32'(q2.size()), 32'd0);
        chk("busy2_end", 32'(busy2), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
